// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube scan datapath sequencer.
package led_cube_pkg;

  localparam int unsigned SR_WIDTH     = 16;
  localparam int unsigned PWM_BITS     = 8;
  localparam int unsigned NUM_LAYERS   = 16;
  localparam int unsigned LAYER_BITS   = 4;
  localparam int unsigned BLANK_CYCLES = 4;
  localparam int unsigned STEP_CYCLES  = SR_WIDTH + 2;
  // One counter serves both the shift run and the blank hold.
  localparam int unsigned CNT_W        = $clog2(SR_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    BLANK,
    BLOAD,
    BSHIFT,
    BLATCH
  } state_e;

endpackage

// File: rtl/led_pwm_sequencer.sv
// PWM step / layer scan sequencer driving all colour shift-register datapaths in lockstep.
// Brightness reload path is built only when LED_SEQ_BRIGHTNESS_EN is defined.
module led_pwm_sequencer
  import led_cube_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  brightness_req,
  output logic [PWM_BITS-1:0]   pwm_time,
  output logic                  load_led_vals,
  output logic                  load_brightness,
  output logic                  shift,
  output logic                  latch,
  output logic                  blank,
  output logic [LAYER_BITS-1:0] layer,
  output logic                  frame_done,
  output logic                  busy
);

  state_e                state_q, state_d, start_state;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [LAYER_BITS-1:0] layer_q, layer_d;
  logic                  lat_q, lat_d;
  logic                  frame_q, frame_d;
  logic                  blank_q, blank_d;
  logic                  lv_q, lv_d;
  logic                  shift_q, shift_d;
  logic                  latch_q, latch_d;
  logic                  busy_q, busy_d;
`ifdef LED_SEQ_BRIGHTNESS_EN
  logic                  pend_q, pend_d;
  logic                  lb_q, lb_d;
`endif

  // Next state, counters and registered strobes (decoded from the next state).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwm_d       = pwm_q;
    layer_d     = layer_q;
    lat_d       = lat_q;
    frame_d     = 1'b0;
    start_state = LOAD;
`ifdef LED_SEQ_BRIGHTNESS_EN
    pend_d = (state_q == BLOAD) ? brightness_req : (pend_q | brightness_req);
    if (pend_q) start_state = BLOAD;
`endif
    case (state_q)
      IDLE: if (enable) state_d = start_state;
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = CNT_W'(SR_WIDTH - 1);
      end
      SHIFT: begin
        if (cnt_q == '0) state_d = LATCH;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      LATCH: begin
        pwm_d = pwm_q + PWM_BITS'(1);
        lat_d = 1'b1;
        // A PWM wrap always forces the layer change; enable is re-checked at BLANK exit.
        if (pwm_q == '1) begin
          state_d = BLANK;
          cnt_d   = CNT_W'(BLANK_CYCLES - 1);
          lat_d   = 1'b0;
          frame_d = (layer_q == LAYER_BITS'(NUM_LAYERS - 1));
          layer_d = frame_d ? '0 : layer_q + LAYER_BITS'(1);
        end else begin
          state_d = enable ? LOAD : IDLE;
        end
      end
      BLANK: begin
        if (cnt_q == '0) state_d = enable ? start_state : IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
`ifdef LED_SEQ_BRIGHTNESS_EN
      BLOAD: begin
        state_d = BSHIFT;
        cnt_d   = CNT_W'(SR_WIDTH - 1);
      end
      BSHIFT: begin
        if (cnt_q == '0) state_d = BLATCH;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      BLATCH: state_d = enable ? LOAD : IDLE;
`endif
      default: state_d = IDLE;
    endcase

    lv_d    = (state_d == LOAD);
    shift_d = (state_d == SHIFT) || (state_d == BSHIFT);
    latch_d = (state_d == LATCH) || (state_d == BLATCH);
    // Drivers stay dark until the layer's first data latch has happened.
    blank_d = !(((state_d == LOAD) || (state_d == SHIFT) || (state_d == LATCH)) && lat_d);
    busy_d  = (state_d != IDLE);
`ifdef LED_SEQ_BRIGHTNESS_EN
    lb_d    = (state_d == BLOAD);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_q   <= '0;
      layer_q <= '0;
      lat_q   <= 1'b0;
      frame_q <= 1'b0;
      blank_q <= 1'b1;
      lv_q    <= 1'b0;
      shift_q <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LED_SEQ_BRIGHTNESS_EN
      pend_q  <= 1'b0;
      lb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      layer_q <= layer_d;
      lat_q   <= lat_d;
      frame_q <= frame_d;
      blank_q <= blank_d;
      lv_q    <= lv_d;
      shift_q <= shift_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
`ifdef LED_SEQ_BRIGHTNESS_EN
      pend_q  <= pend_d;
      lb_q    <= lb_d;
`endif
    end
  end

`ifdef LED_SEQ_BRIGHTNESS_EN
  assign load_brightness = lb_q;
`else
  logic unused_brightness_req;
  assign unused_brightness_req = brightness_req;
  assign load_brightness       = 1'b0;
`endif

  assign pwm_time      = pwm_q;
  assign layer         = layer_q;
  assign load_led_vals = lv_q;
  assign shift         = shift_q;
  assign latch         = latch_q;
  assign blank         = blank_q;
  assign frame_done    = frame_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Self-checking bench for led_pwm_sequencer: vector table, directed corner sequences and a
// segment-level scoreboard model compared every cycle.
module tb_led_pwm_sequencer;
  import led_cube_pkg::*;

`ifdef LED_SEQ_BRIGHTNESS_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif
  localparam int PWM_STEPS = 1 << PWM_BITS;
  localparam int LAYER_CYC = PWM_STEPS * int'(STEP_CYCLES) + int'(BLANK_CYCLES);

  logic                  clk;
  logic                  reset_n;
  logic                  enable;
  logic                  brightness_req;
  logic [PWM_BITS-1:0]   pwm_time;
  logic                  load_led_vals, load_brightness, shift, latch, blank, frame_done, busy;
  logic [LAYER_BITS-1:0] layer;

  led_pwm_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .brightness_req (brightness_req),
    .pwm_time       (pwm_time),
    .load_led_vals  (load_led_vals),
    .load_brightness(load_brightness),
    .shift          (shift),
    .latch          (latch),
    .blank          (blank),
    .layer          (layer),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PWM_BITS-1:0]   pwm;
    logic [LAYER_BITS-1:0] layer;
    logic lv, lb, sh, la, bl, fd, busy;
  } out_t;

  out_t dut_o;
  assign dut_o = {pwm_time, layer, load_led_vals, load_brightness, shift, latch, blank,
                  frame_done, busy};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: whole segments (step, blank hold, brightness reload) are queued as
  // per-cycle expectations; decisions are made only when a segment has been consumed.
  out_t exp_q[$];
  out_t cur;
  int   m_pwm, m_layer, m_last;
  bit   m_run, m_lat, m_pend, m_wrap;

  function automatic out_t mk(bit lv, bit lb, bit sh, bit la, bit bl, bit fd, bit bz);
    out_t r;
    r.pwm = PWM_BITS'(m_pwm);  r.layer = LAYER_BITS'(m_layer);
    r.lv = lv; r.lb = lb; r.sh = sh; r.la = la; r.bl = bl; r.fd = fd; r.busy = bz;
    return r;
  endfunction

  function automatic void push_step();
    for (int i = 0; i < int'(STEP_CYCLES); i++)
      exp_q.push_back(mk(i == 0, 1'b0, i > 0 && i < int'(STEP_CYCLES) - 1,
                         i == int'(STEP_CYCLES) - 1, !m_lat, 1'b0, 1'b1));
    m_wrap = (m_pwm == PWM_STEPS - 1);
    m_pwm  = (m_pwm + 1) % PWM_STEPS;
    m_lat  = 1'b1;
    m_last = 0;
  endfunction

  function automatic void push_blank();
    m_layer = (m_layer + 1) % int'(NUM_LAYERS);
    for (int i = 0; i < int'(BLANK_CYCLES); i++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, i == 0 && m_layer == 0, 1'b1));
    m_lat  = 1'b0;
    m_last = 1;
  endfunction

  function automatic void push_reload();
    for (int i = 0; i < int'(STEP_CYCLES); i++)
      exp_q.push_back(mk(1'b0, i == 0, i > 0 && i < int'(STEP_CYCLES) - 1,
                         i == int'(STEP_CYCLES) - 1, 1'b1, 1'b0, 1'b1));
    m_last = 2;
  endfunction

  function automatic void push_start();
    if (m_pend) push_reload();
    else push_step();
  endfunction

  function automatic void model_tick();
    if (!reset_n) begin
      exp_q.delete();
      m_pwm = 0; m_layer = 0; m_last = 0;
      m_run = 1'b0; m_lat = 1'b0; m_pend = 1'b0; m_wrap = 1'b0;
      cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      if (exp_q.size() == 0) begin
        if (!m_run) begin
          if (enable) begin
            m_run = 1'b1;
            push_start();
          end
        end else if (m_last == 0 && m_wrap) push_blank();
        else if (!enable) m_run = 1'b0;
        else if (m_last == 1) push_start();
        else push_step();
      end
      m_pend = BR_EN && (cur.lb ? brightness_req : (m_pend || brightness_req));
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    model_tick();
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("cycle", dut_o, cur);
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int                  cyc;
    logic                lv, sh, la, bl, bz;
    logic [PWM_BITS-1:0] pwm;
  } vec_t;
  vec_t tbl[7];

  // Waits for the next layer change and measures the strobes up to the following load.
  task automatic boundary(input int tgt, input bit second_req);
    int n, nb, nlb, nsh, nla;
    n = 0;
    do begin @(negedge clk); n++; end while (int'(layer) != tgt && n < LAYER_CYC + 100);
    check("boundary_layer", layer, tgt);
    check("boundary_fd", frame_done, 0);
    nb = 0; nlb = 0; nsh = 0; nla = 0; n = 0;
    while (!load_led_vals && n < 60) begin
      if (blank) nb++;
      if (load_brightness) nlb++;
      if (shift) nsh++;
      if (latch) nla++;
      if (second_req && load_brightness) begin
        brightness_req = 1'b1;
        @(posedge clk); #1 brightness_req = 1'b0;
      end
      @(negedge clk); n++;
    end
    check("boundary_load", load_led_vals, 1);
    check("boundary_blank_cycles", nb, BR_EN ? BLANK_CYCLES + STEP_CYCLES : BLANK_CYCLES);
    check("boundary_lb", nlb, BR_EN ? 1 : 0);
    check("boundary_shifts", nsh, BR_EN ? SR_WIDTH : 0);
    check("boundary_latches", nla, BR_EN ? 1 : 0);
  endtask

  initial begin
    int n, nl, t3, t4;
    //            cyc  lv    sh    la    bl    busy  pwm
    tbl[0] = '{ 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{ 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[2] = '{ 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[3] = '{17, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[4] = '{18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[5] = '{19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[6] = '{20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};

    reset_n = 1'b0; enable = 1'b0; brightness_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", dut_o, {PWM_BITS'(0), LAYER_BITS'(0), 7'b0000100});
    reset_n = 1'b1;

    // First step after enable, against the vector table.
    @(posedge clk); #1 enable = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 7; k++)
        if (tbl[k].cyc == c)
          check($sformatf("first_step_c%0d", c),
                {pwm_time, load_led_vals, shift, latch, blank, busy},
                {tbl[k].pwm, tbl[k].lv, tbl[k].sh, tbl[k].la, tbl[k].bl, tbl[k].bz});
    end

    // Enable dropped mid-shift at pwm_time 7: step completes, then idle holding 8.
    n = 0;
    do begin @(negedge clk); n++; end while (!(pwm_time == 7 && shift) && n < 300);
    check("reach_pwm7", {pwm_time, shift}, {8'd7, 1'b1});
    enable = 1'b0;
    nl = 0; n = 0;
    do begin @(negedge clk); n++; if (latch) nl++; end while (busy && n < 40);
    check("idle_busy", busy, 0);
    check("idle_pwm", pwm_time, 8);
    check("idle_blank", blank, 1);
    check("idle_latches", nl, 1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!load_led_vals && n < 5);
    check("resume_latency", n, 1);
    check("resume_pwm", pwm_time, 8);

    // Brightness request mid-period is held until the layer boundary.
    n = 0;
    do begin @(negedge clk); n++; end while (!(pwm_time == 100 && shift) && n < 2000);
    check("reach_pwm100", pwm_time, 100);
    brightness_req = 1'b1;
    @(posedge clk); #1 brightness_req = 1'b0;
    boundary(1, 1'b1);
    boundary(2, 1'b0);

    // Undisturbed layer period.
    n = 0;
    do begin @(negedge clk); n++; end while (layer != 3 && n < LAYER_CYC + 100);
    t3 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (layer != 4 && n < LAYER_CYC + 100);
    t4 = cyc;
    check("layer_period", t4 - t3, LAYER_CYC);

    // Frame completion on the 15 -> 0 layer wrap.
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 13 * LAYER_CYC);
    check("frame_done_seen", frame_done, 1);
    check("frame_layer", layer, 0);
    check("frame_blank", blank, 1);
    @(negedge clk);
    check("frame_done_width", frame_done, 0);
    check("frame_done_count", fd_cnt, 1);

    // Random enable / request traffic, scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      enable         = ($urandom_range(0, 99) < 85);
      brightness_req = ($urandom_range(0, 29) == 0);
    end

    // Asynchronous reset in the middle of a shift run.
    enable = 1'b1; brightness_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!shift && n < 60);
    check("reach_shift", shift, 1);
    #1 reset_n = 1'b0;
    #1 check("reset_async", dut_o, {PWM_BITS'(0), LAYER_BITS'(0), 7'b0000100});
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      enable         = ($urandom_range(0, 99) < 95);
      brightness_req = ($urandom_range(0, 9) == 0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_sequencer.md
Name: led_pwm_sequencer

Overview:
- Sequences the per-colour shift-register datapath: generates pwm_time, load_led_vals, load_brightness and shift, plus the driver latch and blank strobes and the cube layer select.
- Each PWM step compares pwm_time against the component values, loads the 16 result bits in parallel, shifts them out serially and latches them into the LED drivers.
- One instance drives all colour-component datapaths in lockstep.
- Sits between the frame buffer/layer logic and the colour-component drivers.

Parameters:
- SR_WIDTH, 16, bits per shift-register load (shift cycles per step)
- PWM_BITS, 8, width of pwm_time
- NUM_LAYERS, 16, cube layers multiplexed per frame
- LAYER_BITS, 4, width of layer output
- BLANK_CYCLES, 4, cycles blank is held on each layer change

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run the scan; sampled at step boundaries
- brightness_req  in  1  one-cycle pulse requesting a brightness reload
- pwm_time  out  PWM_BITS  current PWM compare value
- load_led_vals  out  1  parallel-load PWM comparator bits
- load_brightness  out  1  parallel-load brightness word
- shift  out  1  shift one bit out
- latch  out  1  transfer shifted data to driver outputs
- blank  out  1  driver outputs off when high
- layer  out  LAYER_BITS  active layer select
- frame_done  out  1  one-cycle pulse after the last step of the last layer
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: pwm_time=0, layer=0, blank=1, all strobes=0, frame_done=0, busy=0, brightness pending flag=0, state=IDLE. Reset mid-operation aborts immediately with no completion strobes.
- States and timing:
  - IDLE: blank=1. Leaves IDLE when enable=1: goes to BLOAD if brightness is pending, else LOAD.
  - LOAD: 1 cycle, load_led_vals=1.
  - SHIFT: exactly SR_WIDTH cycles, shift=1, down-counter inside.
  - LATCH: 1 cycle, latch=1. On exit, pwm_time increments, wrapping modulo 2^PWM_BITS.
- Step length is 18 cycles (LOAD + 16 SHIFT + LATCH). The strobes are mutually exclusive; at most one is high in any cycle.
- pwm_time is stable from the LOAD cycle through LATCH and changes only on LATCH exit.
- blank=0 during LOAD, SHIFT and LATCH once the first latch of a layer has occurred.
- Layer change:
  - Triggered when pwm_time wraps from 2^PWM_BITS-1 to 0.
  - Enters BLANK for BLANK_CYCLES cycles with blank=1.
  - layer increments in the first BLANK cycle and wraps NUM_LAYERS-1 to 0.
  - frame_done pulses in that same first BLANK cycle when layer wraps.
  - BLANK exits to BLOAD if brightness is pending, else LOAD.
- Brightness reload:
  - A brightness_req pulse sets the pending flag. Repeated requests coalesce.
  - Pending is serviced only at a layer boundary or on exit from IDLE, never mid-period.
  - Service sequence: BLOAD (1 cycle, load_brightness=1), BSHIFT (SR_WIDTH cycles), BLATCH (1 cycle, latch=1).
  - The flag clears in BLOAD. If brightness_req and BLOAD occur in the same cycle, the flag stays set.
  - blank=1 throughout, and pwm_time does not advance.
- enable=0 is honoured only at LATCH exit, BLANK exit and BLATCH exit; the sequencer then goes to IDLE. pwm_time and layer are held, so re-enable resumes at the held step.

Optional Feature:
- Macro: LED_SEQ_BRIGHTNESS_EN.
- Defined: brightness reload path as above.
- Undefined: BLOAD, BSHIFT and BLATCH are not built. load_brightness is tied 0, brightness_req is ignored, and BLANK and IDLE exits always go to LOAD.

Decomposition:
- Shared package led_cube_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, LATCH, BLANK, BLOAD, BSHIFT, BLATCH)
  - constants SR_WIDTH=16, PWM_BITS=8, NUM_LAYERS=16
  - STEP_CYCLES=18
- No sub-module; shift and blank counters stay inline in the FSM.

Test Plan:
- Reset then enable=1 -> first load_led_vals 1 cycle after enable; 16 shift cycles; latch at cycle 18 relative to load; pwm_time goes 0->1 at latch exit.
- Run 256 steps -> pwm_time wraps to 0; blank high for exactly 4 cycles; layer 0->1; no frame_done.
- Run 16 layers -> layer wraps 15->0; frame_done high for one cycle in the first BLANK cycle. Total cycles per frame = 16*(256*18+4) = 73792.
- brightness_req pulsed mid-period at pwm_time=100 -> no effect until the wrap. Then load_brightness, 16 shifts and latch occur with blank=1 before the next load_led_vals. A second request during BLOAD triggers another reload at the next boundary.
- enable dropped during SHIFT at pwm_time=7 -> step completes through latch, IDLE with blank=1, pwm_time=8 held. Re-enable resumes with load at pwm_time=8.
- reset_n asserted during SHIFT -> outputs return immediately to reset values; with macro undefined, load_brightness stays 0 under any brightness_req pattern.
